load_store_unit: RTL and testbench

- CPU-side initiator for the word-organised data RAM. Takes one load/store request at a time from the execute stage and issues word-aligned accesses on the RAM's control/address/data interface.
- Does all byte-lane work itself: lane extraction, sign/zero extension on loads, and read-modify-write merge on byte/halfword stores. The RAM therefore only ever sees full-word reads and full-word writes.
- Returns a single-cycle response carrying the load data or an error flag.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/load_store_lane.sv | 59 +++++
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, access size
// codes and the bit positions inside the RAM control word.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int CTRL_WRITE    = 0;
  localparam int CTRL_BYTE     = 1;
  localparam int CTRL_HALF     = 2;
  localparam int CTRL_UNSIGNED = 3;

endpackage

// File: rtl/load_store_lane.sv
// Byte-lane datapath: extracts and extends load data from a RAM word and merges
// sub-word store data into a RAM word (little-endian lanes).
module load_store_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [15:0] wdata,
  output logic [31:0] load_value,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = word[7:0];
    case (offset)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
    lane_half = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_value = word;
    case (size)
      SIZE_BYTE: load_value = is_unsigned ? {24'h0, lane_byte}
                                          : {{24{lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_value = is_unsigned ? {16'h0, lane_half}
                                          : {{16{lane_half[15]}}, lane_half};
      default:   load_value = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) store_word[31:16] = wdata;
        else           store_word[15:0]  = wdata;
      end
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, full-word RAM accesses only, with
// read-modify-write for byte/halfword stores and a one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [3:0]  mem_control,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output lsu_state_e  debug_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE. resp_valid is a
  // single-cycle pulse, and resp_error/resp_rdata are meaningful only with it.

  lsu_state_e  state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic        mem_we_q;
  logic        req_err;
  logic [31:0] lane_load;
  logic [31:0] lane_store;

  assign req_err = (req_size == 2'b11)
                || (req_size == SIZE_HALF && req_addr[0])
                || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                || (req_addr[31:2] >= 30'(MEM_WORDS));

  assign mem_address = {addr_q[31:2], 2'b00};
  assign debug_state = state;

  always_comb begin
    mem_control             = 4'b0000;
    mem_control[CTRL_WRITE] = mem_we_q;
  end

  load_store_lane u_lane (
    .word        (mem_read_data),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .load_value  (lane_load),
    .store_word  (lane_store)
  );

  // Outputs are registered one state ahead, so the RAM read data seen during
  // ACCESS is consumed directly at the ACCESS exit edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= 32'h0;
      mem_we_q       <= 1'b0;
      mem_write_data <= 32'h0;
      write_q        <= 1'b0;
      size_q         <= 2'b00;
      unsigned_q     <= 1'b0;
      addr_q         <= 32'h0;
      wdata_q        <= 16'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata[15:0];
            req_ready  <= 1'b0;
            resp_rdata <= 32'h0;
            resp_error <= req_err;
            if (req_err) begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
            end else begin
              state <= ST_ACCESS;
              if (req_write && req_size == SIZE_WORD) begin
                mem_we_q       <= 1'b1;
                mem_write_data <= req_wdata;
              end
            end
          end
        end
        ST_ACCESS: begin
          mem_we_q <= 1'b0;
          if (!write_q) begin
            resp_rdata <= lane_load;
            resp_valid <= 1'b1;
            state      <= ST_DONE;
          end else if (size_q == SIZE_WORD) begin
            resp_valid <= 1'b1;
            state      <= ST_DONE;
          end else begin
            mem_we_q       <= 1'b1;
            mem_write_data <= lane_store;
            state          <= ST_MERGE;
          end
        end
        ST_MERGE: begin
          mem_we_q   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_DONE;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural RAM and a
// reference model of load extension, store merge and error rules.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [3:0]  mem_control;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  lsu_state_e  dbg_state;

  logic [31:0] ram     [0:4095];
  logic [31:0] exp_mem [0:4095];
  int          write_count = 0;
  int          errors = 0;
  int          checks = 0;
  logic [32:0] exp_q[$];

  always #5 clock = ~clock;

  load_store_unit #(.MEM_WORDS(4096)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_error     (resp_error),
    .resp_rdata     (resp_rdata),
    .mem_control    (mem_control),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .debug_state    (dbg_state)
  );

  assign mem_read_data = ram[mem_address[13:2]];

  always @(posedge clock) begin
    if (mem_control[0]) begin
      ram[mem_address[13:2]] <= mem_write_data;
      write_count <= write_count + 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic [1:0] s, input logic [31:0] a);
    int unsigned idx;
    idx = a / 4;
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && (a % 2) != 0) return 1'b1;
    if (s == 2'd2 && (a % 4) != 0) return 1'b1;
    return idx >= 4096;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] s,
                                             input logic u, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] lim;
    v = w >> ((a % 4) * 8);
    if (s == 2'd2) return w;
    lim = (s == 2'd0) ? 32'd256 : 32'd65536;
    v = v % lim;
    if (!u && v >= lim / 2) v = v - lim;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] s,
                                              input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (s == 2'd2) return d;
    sh   = (a % 4) * 8;
    mask = ((s == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic err, output logic [31:0] rd,
                       output int nwr);
    int wr0;
    int k;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_size = s; req_unsigned = u;
    req_addr = a; req_wdata = d;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clock); k++; end
    wr0 = write_count;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge clock); #1; lat++; end
    err = resp_error;
    rd  = resp_rdata;
    @(posedge clock);
    #1;
    nwr = write_count - wr0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_error !== 1'b0 ||
        resp_rdata !== 32'h0 || mem_control !== 4'h0 || mem_address !== 32'h0 ||
        mem_write_data !== 32'h0) begin
      errors++;
      $display("FAIL reset: ready=%b rv=%b re=%b rd=%h ctl=%h addr=%h wd=%h, want ready=1 and all else 0",
               req_ready, resp_valid, resp_error, resp_rdata, mem_control, mem_address, mem_write_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_loads;
    int lat; logic err; logic [31:0] rd; int nwr;
    logic [1:0] sz [4]  = '{2'd0, 2'd1, 2'd1, 2'd2};
    logic       un [4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad [4] = '{32'h101, 32'h102, 32'h100, 32'h100};
    logic [31:0] ex [4] = '{32'hFFFFFFBE, 32'h0000DEAD, 32'hFFFFBEEF, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], un[i], ad[i], 32'h0, lat, err, rd, nwr);
      checks++;
      if (rd !== ex[i] || err !== 1'b0 || lat != 2 || nwr != 0) begin
        errors++;
        $display("FAIL load%0d: rdata=%h err=%b lat=%0d writes=%0d, want %h 0 2 0",
                 i, rd, err, lat, nwr, ex[i]);
      end
    end
  endtask

  task automatic test_stores;
    int lat; logic err; logic [31:0] rd; int nwr;
    issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h00000012, lat, err, rd, nwr);
    exp_mem[32'h40] = 32'h12ADBEEF;
    checks++;
    if (ram[32'h40] !== 32'h12ADBEEF || lat != 3 || nwr != 1 || err !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL store_byte: ram=%h lat=%0d writes=%0d err=%b rd=%h, want 12adbeef 3 1 0 0",
               ram[32'h40], lat, nwr, err, rd);
    end
    issue(1'b1, 2'd1, 1'b0, 32'h100, 32'h00005678, lat, err, rd, nwr);
    exp_mem[32'h40] = 32'h12AD5678;
    checks++;
    if (ram[32'h40] !== 32'h12AD5678 || lat != 3 || nwr != 1) begin
      errors++;
      $display("FAIL store_half: ram=%h lat=%0d writes=%0d, want 12ad5678 3 1",
               ram[32'h40], lat, nwr);
    end
    issue(1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, lat, err, rd, nwr);
    exp_mem[32'h41] = 32'hCAFEF00D;
    checks++;
    if (ram[32'h41] !== 32'hCAFEF00D || lat != 2 || nwr != 1) begin
      errors++;
      $display("FAIL store_word: ram=%h lat=%0d writes=%0d, want cafef00d 2 1",
               ram[32'h41], lat, nwr);
    end
  endtask

  task automatic test_errors;
    int lat; logic err; logic [31:0] rd; int nwr;
    logic        wr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic [31:0] ad [4] = '{32'h102, 32'h101, 32'h100, 32'h4000};
    for (int i = 0; i < 4; i++) begin
      issue(wr[i], sz[i], 1'b0, ad[i], 32'h11223344, lat, err, rd, nwr);
      checks++;
      if (err !== 1'b1 || rd !== 32'h0 || lat != 1 || nwr != 0) begin
        errors++;
        $display("FAIL error%0d: err=%b rdata=%h lat=%0d writes=%0d, want 1 0 1 0",
                 i, err, rd, lat, nwr);
      end
    end
    checks++;
    if (ram[32'h40] !== 32'h12AD5678) begin
      errors++;
      $display("FAIL error_nowrite: ram=%h want 12ad5678", ram[32'h40]);
    end
  endtask

  task automatic test_reset_mid_merge;
    int resp_seen = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'hAA;
    @(posedge clock); #1; req_valid = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (mem_control !== 4'b0001) begin
      errors++;
      $display("FAIL merge_we: mem_control=%b want 0001", mem_control);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_control !== 4'b0000) begin
      errors++;
      $display("FAIL reset_drop_we: mem_control=%b want 0000", mem_control);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (resp_valid) resp_seen++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    if (resp_valid) resp_seen++;
    checks++;
    if (ram[32'h40] !== 32'h12AD5678 || resp_seen != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_merge: ram=%h resp_pulses=%0d ready=%b, want 12ad5678 0 1",
               ram[32'h40], resp_seen, req_ready);
    end
  endtask

  task automatic test_back_to_back;
    int n_req = 40;
    int issued = 0;
    int resp_cnt = 0;
    logic acc;
    logic prev_resp = 1'b0;
    logic [32:0] e;
    logic [31:0] a;
    int r;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clock);
      if (issued < n_req && !(req_valid && !req_ready)) begin
        req_valid    = 1'b1;
        req_write    = 1'($urandom_range(0, 1));
        r            = $urandom_range(0, 9);
        req_size     = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        req_unsigned = 1'($urandom_range(0, 1));
        a            = 32'h100 + 32'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) a = 32'h4000 + 32'($urandom_range(0, 255));
        req_addr     = a;
        req_wdata    = $urandom;
      end else if (issued >= n_req) begin
        req_valid = 1'b0;
      end
      acc = req_valid && req_ready;
      @(posedge clock);
      if (acc) begin
        issued++;
        if (model_err(req_size, req_addr)) begin
          exp_q.push_back({1'b1, 32'h0});
        end else if (req_write) begin
          exp_mem[req_addr / 4] = model_store(exp_mem[req_addr / 4], req_size, req_addr, req_wdata);
          exp_q.push_back({1'b0, 32'h0});
        end else begin
          exp_q.push_back({1'b0, model_load(exp_mem[req_addr / 4], req_size, req_unsigned, req_addr)});
        end
      end
      #1;
      if (acc) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_after_accept: ready=%b want 0", req_ready);
        end
      end
      if (resp_valid) begin
        resp_cnt++;
        checks++;
        if (exp_q.size() == 0 || prev_resp || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_resp_protocol: queued=%0d prev_pulse=%b ready=%b, want >0 0 0",
                   exp_q.size(), prev_resp, req_ready);
        end else begin
          e = exp_q.pop_front();
          if ({resp_error, resp_rdata} !== e) begin
            errors++;
            $display("FAIL b2b_resp%0d: err=%b rdata=%h, want err=%b rdata=%h",
                     resp_cnt, resp_error, resp_rdata, e[32], e[31:0]);
          end
        end
      end
      prev_resp = resp_valid;
      if (issued >= n_req && exp_q.size() == 0 && !resp_valid) break;
    end
    req_valid = 1'b0;
    checks++;
    if (resp_cnt != n_req || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: responses=%0d pending=%0d, want %0d 0", resp_cnt, exp_q.size(), n_req);
    end
    for (int w = 32'h40; w < 32'h44; w++) begin
      checks++;
      if (ram[w] !== exp_mem[w]) begin
        errors++;
        $display("FAIL b2b_ram[%0h]: %h want %h", w, ram[w], exp_mem[w]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 32'h0;
      exp_mem[i] = 32'h0;
    end
    ram[32'h40]     = 32'hDEADBEEF;
    exp_mem[32'h40] = 32'hDEADBEEF;
    test_reset;
    test_loads;
    test_stores;
    test_errors;
    test_reset_mid_merge;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
